// File: rtl/next_pc_unit.sv
// next_pc_unit: next fetch address select, hazard hold, and loop halt.
// Ports: clk, reset (sync, active-low), pc, jump/jump_target,
//   branch_taken/branch_target, hazard_stall, resume in;
//   next_pc, pc_stall (combinational), flush, halted (registered) out.
module next_pc_unit #(
    parameter int PC_STEP        = 1,
    parameter int LOOP_THRESHOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        hazard_stall,
    input  logic        resume,
    output logic [15:0] next_pc,
    output logic        pc_stall,
    output logic        flush,
    output logic        halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic [3:0]  cnt_inc;
    logic [15:0] pc_inc;
    logic [15:0] target;
    logic        accept;
    logic        self_tgt;
    logic        resume_ok;

    assign pc_inc   = pc + 16'(PC_STEP);
    assign target   = jump ? jump_target : branch_target;
    assign self_tgt = (target == pc);
    assign cnt_inc  = (cnt == 4'hF) ? 4'hF : cnt + 4'd1;

    assign accept = reset && (state == RUN) && !hazard_stall
                  && (jump || branch_taken);

    assign resume_ok = reset && (state == HALT)
                     && resume && !hazard_stall;

    assign halted = (state == HALT);

    always_comb begin
        next_pc  = pc;
        pc_stall = 1'b0;
        if (!reset) begin
            next_pc = 16'h0000;
        end else begin
            unique case (state)
                RUN: begin
                    if (hazard_stall) begin
                        pc_stall = 1'b1;
                    end else if (jump) begin
                        next_pc = jump_target;
                    end else if (branch_taken) begin
                        next_pc = branch_target;
                    end else begin
                        next_pc = pc_inc;
                    end
                end
                HALT: begin
                    if (resume_ok) begin
                        next_pc = pc_inc;
                    end else begin
                        pc_stall = 1'b1;
                    end
                end
                default: begin
                    next_pc = pc;
                end
            endcase
        end
    end

    // Counter tracks consecutive redirects that land on themselves.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (accept) begin
            cnt_nx = self_tgt ? cnt_inc : 4'd0;
            if (self_tgt && cnt_inc == 4'(LOOP_THRESHOLD)) begin
                state_nx = HALT;
            end
        end else if (resume_ok) begin
            cnt_nx   = 4'd0;
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
            flush <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            flush <= accept;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed and random checks of next_pc_unit
// against a behavioural model of redirect, stall and loop halt.
module tb_next_pc_unit;

    localparam int STEP = 1;
    localparam int THR  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        jump;
    logic [15:0] jump_target;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        hazard_stall;
    logic        resume;
    logic [15:0] next_pc;
    logic        pc_stall;
    logic        flush;
    logic        halted;

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    bit m_halt  = 1'b0;
    int m_run   = 0;
    bit m_flush = 1'b0;

    always #5 clk = ~clk;

    next_pc_unit #(
        .PC_STEP        (STEP),
        .LOOP_THRESHOLD (THR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .hazard_stall  (hazard_stall),
        .resume        (resume),
        .next_pc       (next_pc),
        .pc_stall      (pc_stall),
        .flush         (flush),
        .halted        (halted)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [15:0] seq(input logic [15:0] a);
        return 16'((32'(a) + STEP) % 65536);
    endfunction

    function automatic logic [15:0] exp_npc();
        if (!reset) return 16'h0000;
        if (m_halt) begin
            if (resume && !hazard_stall) return seq(pc);
            return pc;
        end
        if (hazard_stall) return pc;
        if (jump) return jump_target;
        if (branch_taken) return branch_target;
        return seq(pc);
    endfunction

    function automatic bit exp_stall();
        if (!reset) return 1'b0;
        if (m_halt) return !(resume && !hazard_stall);
        return hazard_stall;
    endfunction

    task automatic model_edge();
        logic [15:0] tgt;
        if (!reset) begin
            m_halt  = 1'b0;
            m_run   = 0;
            m_flush = 1'b0;
        end else if (!m_halt && !hazard_stall
                     && (jump || branch_taken)) begin
            m_flush = 1'b1;
            tgt = jump ? jump_target : branch_target;
            if (tgt == pc) begin
                m_run = (m_run >= 15) ? 15 : m_run + 1;
                if (m_run == THR) m_halt = 1'b1;
            end else begin
                m_run = 0;
            end
        end else begin
            m_flush = 1'b0;
            if (m_halt && resume && !hazard_stall) begin
                m_halt = 1'b0;
                m_run  = 0;
            end
        end
    endtask

    task automatic tick();
        #1;
        chk("next_pc", 32'(next_pc), 32'(exp_npc()));
        chk("pc_stall", 32'(pc_stall), 32'(exp_stall()));
        @(posedge clk);
        model_edge();
        #1;
        chk("flush", 32'(flush), 32'(m_flush));
        chk("halted", 32'(halted), 32'(m_halt));
    endtask

    task automatic idle();
        jump          = 1'b0;
        branch_taken  = 1'b0;
        hazard_stall  = 1'b0;
        resume        = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        pc            = 16'h1234;
        idle();
        jump          = 1'b1;
        jump_target   = 16'h0055;
        branch_target = 16'h0000;
        #2;
        tick();
        tick();
        chk("rst_halted", 32'(halted), 32'd0);

        reset = 1'b1;
        idle();
        pc = 16'h0010;
        #1;
        chk("seq_step", 32'(next_pc), 32'h0011);
        tick();

        pc = 16'hFFFF;
        #1;
        chk("wrap", 32'(next_pc), 32'h0000);
        tick();
        chk("wrap_flush", 32'(flush), 32'd0);

        pc            = 16'h0100;
        jump          = 1'b1;
        jump_target   = 16'h0080;
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        #1;
        chk("prio", 32'(next_pc), 32'h0080);
        tick();
        chk("prio_flush", 32'(flush), 32'd1);
        idle();
        pc = 16'h0080;
        tick();
        chk("flush_once", 32'(flush), 32'd0);

        pc            = 16'h0030;
        hazard_stall  = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        #1;
        chk("hz_npc", 32'(next_pc), 32'h0030);
        chk("hz_stall", 32'(pc_stall), 32'd1);
        tick();
        chk("hz_flush", 32'(flush), 32'd0);
        idle();

        pc          = 16'h0020;
        jump        = 1'b1;
        jump_target = 16'h0020;
        tick();
        chk("loop_one", 32'(halted), 32'd0);
        tick();
        chk("loop_halt", 32'(halted), 32'd1);
        idle();
        #1;
        chk("halt_npc", 32'(next_pc), 32'h0020);
        chk("halt_stall", 32'(pc_stall), 32'd1);
        tick();
        resume = 1'b1;
        #1;
        chk("res_npc", 32'(next_pc), 32'h0021);
        chk("res_stall", 32'(pc_stall), 32'd0);
        tick();
        chk("res_run", 32'(halted), 32'd0);
        idle();

        jump = 1'b1;
        tick();
        tick();
        chk("halt2", 32'(halted), 32'd1);
        idle();
        reset = 1'b0;
        tick();
        chk("rst_in_halt", 32'(halted), 32'd0);
        reset = 1'b1;
        jump  = 1'b1;
        tick();
        chk("no_halt", 32'(halted), 32'd0);
        idle();
        tick();

        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 39) != 0);
            hazard_stall = ($urandom_range(0, 5) == 0);
            resume       = ($urandom_range(0, 3) == 0);
            jump         = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: pc = 16'h0020;
                1: pc = 16'hFFFF;
                default: pc = 16'($urandom);
            endcase
            jump_target   = ($urandom_range(0, 1) == 0)
                          ? pc : 16'($urandom);
            branch_target = ($urandom_range(0, 1) == 0)
                          ? pc : 16'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
